// File: rtl/ram_arb2.sv
// rtl/ram_arb2.sv - two-port round-robin arbiter sharing one byte-enabled single-port RAM
module ram_arb2 #(
    parameter int ADDRWIDTH = 14,
    parameter int MAX_BURST = 4
) (
    input  logic                 bus_clk,
    input  logic                 bus_reset_l,
    input  logic                 a_req,
    input  logic [3:0]           a_be,
    input  logic [ADDRWIDTH-1:0] a_addr,
    input  logic [31:0]          a_wr_data,
    output logic                 a_ack,
    output logic                 a_rd_valid,
    output logic [31:0]          a_rd_data,
    input  logic                 b_req,
    input  logic [3:0]           b_be,
    input  logic [ADDRWIDTH-1:0] b_addr,
    input  logic [31:0]          b_wr_data,
    output logic                 b_ack,
    output logic                 b_rd_valid,
    output logic [31:0]          b_rd_data,
    output logic [3:0]           ram_we,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic [31:0]          ram_wr_data,
    input  logic [31:0]          ram_rd_data
);

    localparam int RUNW = $clog2(MAX_BURST + 1);
    localparam logic [RUNW-1:0] RUN_MAX = RUNW'(MAX_BURST);
    localparam logic [RUNW-1:0] RUN_ONE = RUNW'(1);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    port_t          last;
    logic [RUNW-1:0] run;
    logic           a_pend_rd;
    logic           b_pend_rd;
    logic           grant_a;
    logic           grant_b;
    logic           keep_last;
    port_t          winner;

    // Grant decision. run == 0 only right after reset, when there is no burst
    // to continue, so a tie then goes to the port other than last (A).
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        keep_last = 1'b0;
        if (bus_reset_l) begin
            if (a_req && b_req) begin
                keep_last = (run != '0) && (run < RUN_MAX);
                if (keep_last ? (last == PORT_A) : (last == PORT_B)) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    // RAM request mux; with no grant the A qualifiers pass through with writes blocked.
    always_comb begin
        ram_addr    = a_addr;
        ram_wr_data = a_wr_data;
        ram_we      = 4'b0000;
        winner      = PORT_A;
        if (grant_a) begin
            ram_we = a_be;
        end else if (grant_b) begin
            ram_addr    = b_addr;
            ram_wr_data = b_wr_data;
            ram_we      = b_be;
            winner      = PORT_B;
        end
    end

    assign a_ack = grant_a;
    assign b_ack = grant_b;

    // Read strobes are also masked by reset so a read acked just before reset delivers nothing.
    assign a_rd_valid = a_pend_rd & bus_reset_l;
    assign b_rd_valid = b_pend_rd & bus_reset_l;
    assign a_rd_data  = a_rd_valid ? ram_rd_data : 32'h0000_0000;
    assign b_rd_data  = b_rd_valid ? ram_rd_data : 32'h0000_0000;

    // Round-robin history and one-cycle read-valid pipeline.
    always_ff @(posedge bus_clk) begin
        if (!bus_reset_l) begin
            last      <= PORT_B;
            run       <= '0;
            a_pend_rd <= 1'b0;
            b_pend_rd <= 1'b0;
        end else begin
            a_pend_rd <= grant_a && (a_be == 4'b0000);
            b_pend_rd <= grant_b && (b_be == 4'b0000);
            if (grant_a || grant_b) begin
                if (winner == last) begin
                    if (run != RUN_MAX) begin
                        run <= run + RUN_ONE;
                    end
                end else begin
                    last <= winner;
                    run  <= RUN_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_arb2.sv
// tb/tb_ram_arb2.sv - directed self-checking bench for ram_arb2
module tb_ram_arb2;

    localparam int AW = 14;

    logic          bus_clk = 1'b0;
    logic          bus_reset_l;
    logic          a_req, b_req;
    logic [3:0]    a_be, b_be;
    logic [AW-1:0] a_addr, b_addr;
    logic [31:0]   a_wr_data, b_wr_data;

    logic          a_ack, a_rd_valid, b_ack, b_rd_valid;
    logic [31:0]   a_rd_data, b_rd_data;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wr_data;
    logic [31:0]   ram_rd_data;

    logic          a1_ack, a1_rd_valid, b1_ack, b1_rd_valid;
    logic [31:0]   a1_rd_data, b1_rd_data;
    logic [3:0]    ram1_we;
    logic [AW-1:0] ram1_addr;
    logic [31:0]   ram1_wr_data;
    logic [31:0]   ram1_rd_data;

    logic [31:0]   mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 bus_clk = ~bus_clk;

    ram_arb2 #(.ADDRWIDTH(AW), .MAX_BURST(4)) dut (
        .bus_clk(bus_clk), .bus_reset_l(bus_reset_l),
        .a_req(a_req), .a_be(a_be), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_ack(a_ack), .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
        .b_req(b_req), .b_be(b_be), .b_addr(b_addr), .b_wr_data(b_wr_data),
        .b_ack(b_ack), .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data)
    );

    ram_arb2 #(.ADDRWIDTH(AW), .MAX_BURST(1)) dut1 (
        .bus_clk(bus_clk), .bus_reset_l(bus_reset_l),
        .a_req(a_req), .a_be(a_be), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_ack(a1_ack), .a_rd_valid(a1_rd_valid), .a_rd_data(a1_rd_data),
        .b_req(b_req), .b_be(b_be), .b_addr(b_addr), .b_wr_data(b_wr_data),
        .b_ack(b1_ack), .b_rd_valid(b1_rd_valid), .b_rd_data(b1_rd_data),
        .ram_we(ram1_we), .ram_addr(ram1_addr), .ram_wr_data(ram1_wr_data),
        .ram_rd_data(ram1_rd_data)
    );

    // Byte-enabled single-port RAM model, read returns old data on read-during-write.
    always @(posedge bus_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_wr_data[8*i +: 8];
        end
        ram_rd_data <= mem[ram_addr[7:0]];
    end

    task automatic tick;
        @(posedge bus_clk);
        #1;
    endtask

    task automatic do_reset;
        bus_reset_l = 1'b0;
        tick();
        bus_reset_l = 1'b1;
    endtask

    task automatic test_reset;
        a_req = 1'b1; b_req = 1'b1; a_be = 4'hF; b_be = 4'hF;
        a_addr = 14'd1; b_addr = 14'd2;
        bus_reset_l = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge bus_clk);
            checks++;
            if ({a_ack, b_ack} !== 2'b00) begin
                errors++; $display("FAIL reset_acks got %b want 00", {a_ack, b_ack});
            end
            checks++;
            if (ram_we !== 4'h0) begin
                errors++; $display("FAIL reset_ram_we got %h want 0", ram_we);
            end
            checks++;
            if ({a_rd_valid, b_rd_valid, a1_rd_valid, b1_rd_valid} !== 4'b0000) begin
                errors++; $display("FAIL reset_rd_valid got %b want 0000",
                                   {a_rd_valid, b_rd_valid, a1_rd_valid, b1_rd_valid});
            end
            checks++;
            if ({a1_ack, b1_ack, ram1_we} !== 6'b0) begin
                errors++; $display("FAIL reset_dut1 got %b want 0", {a1_ack, b1_ack, ram1_we});
            end
            checks++;
            if ((a_rd_data | b_rd_data | a1_rd_data | b1_rd_data) !== 32'h0) begin
                errors++; $display("FAIL reset_rd_data got nonzero want 0");
            end
            tick();
        end
        bus_reset_l = 1'b1;
        @(negedge bus_clk);
        checks++;
        if ({a_ack, b_ack} !== 2'b10) begin
            errors++; $display("FAIL first_tie got a=%b b=%b want a=1 b=0", a_ack, b_ack);
        end
        tick();
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_burst;
        logic [8:0] seq0;
        logic [8:0] seq1;
        logic [1:0] want0;
        logic [1:0] want1;
        seq0 = 9'b0_1111_0000;
        seq1 = 9'b0_1010_1010;
        a_be = 4'hF; b_be = 4'hF;
        a_addr = 14'd200; b_addr = 14'd201;
        a_wr_data = 32'h0000_A0A0; b_wr_data = 32'h0000_B0B0;
        a_req = 1'b1; b_req = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge bus_clk);
            want0 = seq0[i] ? 2'b10 : 2'b01;
            want1 = seq1[i] ? 2'b10 : 2'b01;
            checks++;
            if ({b_ack, a_ack} !== want0) begin
                errors++; $display("FAIL burst4_grant[%0d] got %b want %b", i, {b_ack, a_ack}, want0);
            end
            checks++;
            if ({b1_ack, a1_ack} !== want1) begin
                errors++; $display("FAIL burst1_grant[%0d] got %b want %b", i, {b1_ack, a1_ack}, want1);
            end
            checks++;
            if (ram1_addr !== (seq1[i] ? 14'd201 : 14'd200) ||
                ram1_wr_data !== (seq1[i] ? 32'h0000_B0B0 : 32'h0000_A0A0)) begin
                errors++; $display("FAIL burst1_mux[%0d] got addr=%0d data=%h", i, ram1_addr, ram1_wr_data);
            end
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_single_port;
        do_reset();
        a_req = 1'b1; a_be = 4'hF; a_addr = 14'd5; a_wr_data = 32'hDEAD_BEEF;
        @(negedge bus_clk);
        checks++;
        if (a_ack !== 1'b1 || ram_we !== 4'hF || ram_addr !== 14'd5 || ram_wr_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sp_write got ack=%b we=%h addr=%0d data=%h", a_ack, ram_we, ram_addr, ram_wr_data);
        end
        tick();
        a_be = 4'h0;
        @(negedge bus_clk);
        checks++;
        if (a_ack !== 1'b1 || ram_we !== 4'h0 || a_rd_valid !== 1'b0) begin
            errors++; $display("FAIL sp_read_req got ack=%b we=%h rdv=%b", a_ack, ram_we, a_rd_valid);
        end
        tick();
        a_req = 1'b0;
        @(negedge bus_clk);
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL sp_read_data got v=%b d=%h want 1 deadbeef", a_rd_valid, a_rd_data);
        end
        checks++;
        if (b_rd_valid !== 1'b0 || b_rd_data !== 32'h0) begin
            errors++; $display("FAIL sp_b_quiet got v=%b d=%h want 0", b_rd_valid, b_rd_data);
        end
        tick();
        @(negedge bus_clk);
        checks++;
        if (a_rd_valid !== 1'b0 || a_rd_data !== 32'h0) begin
            errors++; $display("FAIL sp_valid_one_cycle got v=%b d=%h want 0", a_rd_valid, a_rd_data);
        end
        tick();
    endtask

    task automatic test_byte_enables;
        a_req = 1'b1; a_be = 4'hF; a_addr = 14'd7; a_wr_data = 32'h1122_3344;
        tick();
        a_req = 1'b0;
        b_req = 1'b1; b_be = 4'b0010; b_addr = 14'd7; b_wr_data = 32'h0000_AA00;
        @(negedge bus_clk);
        checks++;
        if (b_ack !== 1'b1 || ram_we !== 4'b0010 || ram_addr !== 14'd7) begin
            errors++; $display("FAIL be_write got ack=%b we=%b addr=%0d", b_ack, ram_we, ram_addr);
        end
        tick();
        b_be = 4'b0000;
        tick();
        b_req = 1'b0;
        @(negedge bus_clk);
        checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h1122_AA44) begin
            errors++; $display("FAIL be_merge got v=%b d=%h want 1 1122aa44", b_rd_valid, b_rd_data);
        end
        checks++;
        if (a_rd_valid !== 1'b0) begin
            errors++; $display("FAIL be_a_quiet got %b want 0", a_rd_valid);
        end
        tick();
    endtask

    task automatic test_late_arrival;
        a_req = 1'b0; b_req = 1'b0;
        do_reset();
        a_req = 1'b1; a_be = 4'hF; a_addr = 14'd10; a_wr_data = 32'h0000_0010;
        for (int i = 0; i < 10; i++) begin
            @(negedge bus_clk);
            checks++;
            if ({a_ack, b_ack} !== 2'b10) begin
                errors++; $display("FAIL late_a_alone[%0d] got %b want 10", i, {a_ack, b_ack});
            end
            tick();
        end
        b_req = 1'b1; b_be = 4'hF; b_addr = 14'd11; b_wr_data = 32'h0000_0011;
        @(negedge bus_clk);
        checks++;
        if ({a_ack, b_ack} !== 2'b01) begin
            errors++; $display("FAIL late_b_grant got %b want 01", {a_ack, b_ack});
        end
        tick();
        b_req = 1'b0;
        @(negedge bus_clk);
        checks++;
        if ({a_ack, b_ack} !== 2'b10) begin
            errors++; $display("FAIL late_a_resume got %b want 10", {a_ack, b_ack});
        end
        tick();
        a_req = 1'b0;
    endtask

    task automatic test_withdraw;
        a_req = 1'b0; b_req = 1'b0;
        do_reset();
        a_req = 1'b1; a_be = 4'hF; a_addr = 14'd20; a_wr_data = 32'h1234_5678;
        tick();
        a_be = 4'h0;
        b_req = 1'b1; b_be = 4'hF; b_addr = 14'd20; b_wr_data = 32'hCAFE_F00D;
        @(negedge bus_clk);
        checks++;
        if ({a_ack, b_ack} !== 2'b10 || ram_we !== 4'h0) begin
            errors++; $display("FAIL wd_hold got acks=%b we=%h want 10 0", {a_ack, b_ack}, ram_we);
        end
        tick();
        b_req = 1'b0; a_req = 1'b0;
        @(negedge bus_clk);
        checks++;
        if (b_ack !== 1'b0 || a_rd_valid !== 1'b1 || a_rd_data !== 32'h1234_5678) begin
            errors++; $display("FAIL wd_read got back=%b v=%b d=%h", b_ack, a_rd_valid, a_rd_data);
        end
        tick();
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        @(negedge bus_clk);
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 32'h1234_5678) begin
            errors++; $display("FAIL wd_ram_untouched got v=%b d=%h want 1 12345678", a_rd_valid, a_rd_data);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        a_req = 1'b1; a_be = 4'h0; a_addr = 14'd5;
        @(negedge bus_clk);
        checks++;
        if (a_ack !== 1'b1) begin
            errors++; $display("FAIL rm_ack got %b want 1", a_ack);
        end
        tick();
        a_req = 1'b0;
        bus_reset_l = 1'b0;
        @(negedge bus_clk);
        checks++;
        if (a_rd_valid !== 1'b0 || a_rd_data !== 32'h0) begin
            errors++; $display("FAIL rm_in_reset got v=%b d=%h want 0", a_rd_valid, a_rd_data);
        end
        tick();
        bus_reset_l = 1'b1;
        @(negedge bus_clk);
        checks++;
        if (a_rd_valid !== 1'b0 || a_rd_data !== 32'h0) begin
            errors++; $display("FAIL rm_after_reset got v=%b d=%h want 0", a_rd_valid, a_rd_data);
        end
        tick();
    endtask

    initial begin
        ram1_rd_data = 32'h0;
        bus_reset_l = 1'b0;
        a_req = 1'b0; b_req = 1'b0;
        a_be = 4'h0; b_be = 4'h0;
        a_addr = '0; b_addr = '0;
        a_wr_data = 32'h0; b_wr_data = 32'h0;
        tick();
        test_reset();
        test_burst();
        test_single_port();
        test_byte_enables();
        test_late_arrival();
        test_withdraw();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arb2.md
Name: ram_arb2

Overview:
- Two-requester arbiter that shares one single-port, byte-enabled, 32-bit synchronous RAM (ram_sp_be) between port A and port B.
- Typical pairing: A = bus-slave front end, B = capture/stream engine writing sample data.
- Round-robin with a configurable burst allowance.
- Zero-latency grant (ack in the request cycle); read data returned one cycle later with a per-port valid strobe.

Parameters:
ADDRWIDTH, 14, RAM word-address width (RAM depth = 2^ADDRWIDTH 32-bit words)
MAX_BURST, 4, max consecutive grants to one port while the other is waiting; must be >= 1 (1 = strict alternation)

Ports:
bus_clk  in  1  clock
bus_reset_l  in  1  synchronous active-low reset
a_req  in  1  port A access request; held with its qualifiers until a_ack
a_be  in  4  port A byte enables; 0 = read, nonzero = write of enabled bytes
a_addr  in  ADDRWIDTH  port A word address
a_wr_data  in  32  port A write data
a_ack  out  1  port A access accepted this cycle (combinational)
a_rd_valid  out  1  port A read data valid (registered)
a_rd_data  out  32  port A read data; 0 when a_rd_valid low
b_req, b_be, b_addr, b_wr_data, b_ack, b_rd_valid, b_rd_data  same as port A, for port B
ram_we  out  4  RAM byte write enables
ram_addr  out  ADDRWIDTH  RAM word address
ram_wr_data  out  32  RAM write data
ram_rd_data  in  32  RAM read data, valid the cycle after ram_addr is presented

Behaviour:
- State: last (1 bit, port granted most recently), run (counter sized to hold MAX_BURST: consecutive grants to last), a_pend_rd and b_pend_rd (registered read strobes).
- Reset (bus_reset_l low at a bus_clk edge): last = B, run = 0, both rd_valid = 0.
- Reset outputs: acks follow the combinational rule but are forced 0 while bus_reset_l is low; ram_we = 0; rd_data = 0.
- Grant decision, combinational each cycle:
  - Neither requests: no grant.
  - Only one requests: that port wins.
  - Both request: last wins if run < MAX_BURST; otherwise the other port wins.
  - After reset, a tie goes to A.
- Grant outputs:
  - Granted port's ack = 1 in the same cycle.
  - ram_addr / ram_wr_data = granted port's addr / wr_data.
  - ram_we = granted port's be.
  - No grant: ram_we = 0; ram_addr / ram_wr_data = port A values (don't-care, but no writes).
- State update at the clock edge:
  - Grant to the same port as last: run = min(run+1, MAX_BURST), saturating.
  - Grant to the other port: last = winner, run = 1.
  - No grant: last and run hold.
- Read path:
  - A granted access with be == 0 sets that port's rd_valid for exactly the next cycle.
  - x_rd_data = ram_rd_data when x_rd_valid, else 0.
  - Writes never raise rd_valid.
- Throughput and ordering:
  - One access per cycle total.
  - Back-to-back reads from one port give rd_valid on consecutive cycles.
  - Per-port order is preserved.
- Requester rules:
  - Qualifiers must be stable while req is high and ack is low.
  - Dropping req before ack is legal and withdraws the request; no state change.
- Starvation bound: a waiting port is granted within MAX_BURST cycles of the other port's continuous requests.
- Write and read to the same address in adjacent cycles (either port): the read returns the RAM's behaviour (old/new per ram_sp_be read-during-write). The arbiter adds no forwarding.
- Reset mid-operation:
  - A pending rd_valid is cleared; no data is delivered for a read acked in the cycle before reset.
  - Requesters must re-issue after reset.

Test Plan:
- Reset: hold bus_reset_l low 3 cycles with a_req = b_req = 1 -> acks 0, ram_we 0, rd_valid 0.
- Release reset: first tie grants A.
- Single port: A writes be = 4'hF, addr 5, data 32'hDEADBEEF, then reads addr 5.
  - a_ack in each request cycle.
  - a_rd_valid one cycle after the read ack, a_rd_data = 32'hDEADBEEF.
  - b_rd_valid stays 0.
- Byte enables: A writes 32'h11223344 to addr 7; B writes be = 4'b0010, data 32'h0000AA00 to addr 7; B reads addr 7 -> b_rd_data = 32'h1122AA44.
- Burst/fairness, MAX_BURST = 4, both requesting continuously from reset:
  - Grant sequence A,A,A,A,B,B,B,B,A.
  - With MAX_BURST = 1: strict A,B,A,B.
- Late arrival: A requests alone for 10 cycles, then B raises req -> B granted within 4 cycles, then A resumes.
- Withdraw and reset: B raises req for one cycle while A holds grant with run < 4 -> B never acked, RAM untouched. Assert reset the cycle after an A read ack -> a_rd_valid stays 0.
